// File: rtl/multiport_register_file.sv
// multiport_register_file
//   RISC-V integer register file with NUM_READ combinational read ports and
//   one synchronous write port. x0 always reads as zero and has no storage.
//   After reset, or when clear_req is seen in IDLE, a sweep zeroes entries
//   1..TOTAL_REGS-1 one per clock. ready is low during the sweep, and all
//   read ports return zero while ready is low.
//
//   Optional feature macro: RF_WB_BYPASS_EN. When it is defined, an accepted
//   write is forwarded to any read port that addresses the same register in
//   the same cycle.
//
// Ports
//   clk, rst_n  rising-edge clock; asynchronous active-low reset
//   clear_req   start a zero sweep (sampled only in IDLE)
//   ready       1 = sweep finished, contents valid
//   wr_en, wr_addr, wr_data   write port
//   wr_drop     registered one-cycle pulse when a write was discarded
//   rd_addr     packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data     packed read data,      port p at [p*DATA_WIDTH +: DATA_WIDTH]
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TOTAL_REGS = 32,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_req,
  output logic                           ready,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_drop,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data
);

  typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

  localparam logic [ADDR_WIDTH:0]   NREGS    = (ADDR_WIDTH+1)'(TOTAL_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    ready_q, ready_d;
  logic                    wr_drop_q, wr_drop_d;
  logic                    wr_hit;
  logic [DATA_WIDTH-1:0]   regs_q [1:TOTAL_REGS-1];
  logic [DATA_WIDTH-1:0]   regs_d [1:TOTAL_REGS-1];

  logic wr_in_range;
  assign wr_in_range = (wr_addr != '0) && ({1'b0, wr_addr} < NREGS);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    wr_hit    = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        idx_d     = idx_q + ONE_IDX;
        wr_drop_d = wr_en && (wr_addr != '0);
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          // Clear wins over a simultaneous write; that write is reported as dropped.
          state_d   = ST_SWEEP;
          idx_d     = ONE_IDX;
          ready_d   = 1'b0;
          wr_drop_d = wr_en && (wr_addr != '0);
        end else if (wr_en) begin
          wr_hit    = wr_in_range;
          wr_drop_d = !wr_in_range && (wr_addr != '0);
        end
      end
      default: begin
        state_d = ST_SWEEP;
        idx_d   = ONE_IDX;
        ready_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    for (int unsigned i = 1; i < TOTAL_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (state_q == ST_SWEEP && idx_q == ADDR_WIDTH'(i)) begin
        regs_d[i] = '0;
      end else if (wr_hit && wr_addr == ADDR_WIDTH'(i)) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NUM_READ; p++) begin
      logic [ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] v;
      a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      v = '0;
      if (ready_q) begin
        // Addresses 0 and >= TOTAL_REGS match no entry and so read zero.
        for (int unsigned i = 1; i < TOTAL_REGS; i++) begin
          if (a == ADDR_WIDTH'(i)) v = regs_q[i];
        end
`ifdef RF_WB_BYPASS_EN
        if (wr_hit && a == wr_addr) v = wr_data;
`endif
      end
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SWEEP;
      idx_q     <= ONE_IDX;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset; it is unreadable until the sweep has zeroed it.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear_req = 1'b0;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic           ready32, ready24, drop32, drop24;
  logic [NR*DW-1:0] rd32, rd24;

  multiport_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_REGS(32), .NUM_READ(NR)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready32),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(drop32),
    .rd_addr(rd_addr), .rd_data(rd32));

  multiport_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_REGS(24), .NUM_READ(NR)) dut24 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready24),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(drop24),
    .rd_addr(rd_addr), .rd_data(rd24));

  always #5 clk = ~clk;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: index 0 models the 32-entry file, index 1 the 24-entry file.
  // A sweep zeroes the model at once; the countdown covers the unreadable window.
  logic [DW-1:0] mdl [2][32];
  int            cd  [2];
  bit            drp [2];
  int            nregs [2] = '{32, 24};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cd[k] = nregs[k] - 1;
        drp[k] = 1'b0;
        for (int j = 0; j < 32; j++) mdl[k][j] = '0;
      end else if (cd[k] > 0) begin
        cd[k] = cd[k] - 1;
        drp[k] = wr_en && (wr_addr != 0);
      end else if (clear_req) begin
        cd[k] = nregs[k] - 1;
        drp[k] = wr_en && (wr_addr != 0);
        for (int j = 0; j < 32; j++) mdl[k][j] = '0;
      end else begin
        drp[k] = wr_en && (int'(wr_addr) >= nregs[k]);
        if (wr_en && wr_addr != 0 && int'(wr_addr) < nregs[k]) mdl[k][wr_addr] = wr_data;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(int k, int a);
    if (cd[k] != 0 || a == 0 || a >= nregs[k]) return '0;
    if (BYP && rst_n && wr_en && !clear_req && int'(wr_addr) == a) return wr_data;
    return mdl[k][a];
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_all();
    logic [NR*DW-1:0] rdv;
    logic r, d;
    int a;
    for (int k = 0; k < 2; k++) begin
      rdv = (k == 0) ? rd32 : rd24;
      r   = (k == 0) ? ready32 : ready24;
      d   = (k == 0) ? drop32 : drop24;
      chk($sformatf("ready_n%0d", nregs[k]), 64'(r), 64'(cd[k] == 0));
      chk($sformatf("wr_drop_n%0d", nregs[k]), 64'(d), 64'(drp[k]));
      for (int p = 0; p < NR; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        chk($sformatf("rd_n%0d_p%0d_a%0d", nregs[k], p, a),
            64'(rdv[p*DW +: DW]), 64'(exp_rd(k, a)));
      end
    end
  endtask

  // Compare at the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int e32, output int e24);
    e32 = -1;
    e24 = -1;
    for (int c = 1; c <= 40; c++) begin
      rd_addr = NR*AW'($urandom);
      step();
      if (e32 < 0 && ready32) e32 = c;
      if (e24 < 0 && ready24) e24 = c;
    end
  endtask

  initial begin
    int e32, e24;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // 1: sweep after reset release
    wait_ready(e32, e24);
    chk("t1_sweep_edges32", 64'(e32), 64'd31);
    chk("t1_sweep_edges24", 64'(e24), 64'd23);

    // 2: plain write, duplicate read ports; write to x0
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
    step();
    wr_en = 1'b0;
    #1 chk("t2_x5_both", 64'(rd32), {2{32'hDEADBEEF}});
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd5, 5'd0};
    step();
    wr_en = 1'b0;
    #1 chk("t2_x0", 64'(rd32[DW-1:0]), 64'd0);
    chk("t2_x0_drop", 64'(drop32), 64'd0);

    // 3: same-cycle read of the register being written
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd7};
    #1 chk("t3_same_cycle", 64'(rd32), BYP ? {2{32'hA5A5A5A5}} : 64'd0);
    step();
    wr_en = 1'b0;
    #1 chk("t3_next_cycle", 64'(rd32), {2{32'hA5A5A5A5}});

    // 4: clear wins over a simultaneous write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    step();
    clear_req = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    step();
    clear_req = 1'b0; wr_en = 1'b0;
    chk("t4_drop_pulse", 64'(drop32), 64'd1);
    @(negedge clk); compare_all(); @(posedge clk); #1;
    chk("t4_drop_once", 64'(drop32), 64'd0);
    wait_ready(e32, e24);
    chk("t4_sweep_edges32", 64'(e32), 64'd30);
    rd_addr = {5'd9, 5'd3};
    #1 chk("t4_x3_x9_zero", 64'(rd32), 64'd0);
    step();

    // 5: write beyond TOTAL_REGS on the 24-entry file
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'hFF;
    step();
    wr_en = 1'b0; rd_addr = {5'd30, 5'd30};
    #1 chk("t5_drop24", 64'(drop24), 64'd1);
    chk("t5_rd24_a30", 64'(rd24), 64'd0);
    chk("t5_rd32_a30", 64'(rd32), {2{32'hFF}});
    for (int a = 0; a < 32; a++) begin
      rd_addr = {AW'(a), AW'(31 - a)};
      step();
    end

    // 6: reset in IDLE drops ready at once; reset mid-sweep restarts the sweep
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h99;
    step();
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1 chk("t6_async_ready", 64'(ready32), 64'd0);
    step();
    rst_n = 1'b1;
    wait_ready(e32, e24);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h99;
    step();
    wr_en = 1'b0; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    #1 chk("t6_ready_low", 64'(ready32), 64'd0);
    step();
    rst_n = 1'b1;
    wait_ready(e32, e24);
    chk("t6_sweep_edges32", 64'(e32), 64'd31);
    rd_addr = {5'd12, 5'd12};
    #1 chk("t6_x12_zero", 64'(rd32), 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      clear_req = ($urandom_range(0, 79) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom);
      wr_data   = $urandom;
      rd_addr   = NR*AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[2*AW-1:AW] = wr_addr;
      step();
    end
    rst_n = 1'b1; clear_req = 1'b0; wr_en = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
